// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 bus responder: FSM states, instruction
// opcode masks, error bit positions and the blank character used by clear.
package hd44780_pkg;

  typedef enum logic [1:0] {
    INIT8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int ERR_BUSY    = 0;
  localparam int ERR_SHORT_E = 1;
  localparam int ERR_RS      = 2;
  localparam int ERR_RW      = 3;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Instruction classes are matched as (byte & mask) == value.
  localparam logic [7:0] OP_CLEAR_MASK = 8'hFF, OP_CLEAR_VAL = 8'h01;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE, OP_HOME_VAL  = 8'h02;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC, OP_ENTRY_VAL = 8'h04;
  localparam logic [7:0] OP_DISP_MASK  = 8'hF8, OP_DISP_VAL  = 8'h08;
  localparam logic [7:0] OP_SHIFT_MASK = 8'hF0, OP_SHIFT_VAL = 8'h10;
  localparam logic [7:0] OP_FUNC_MASK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
  localparam logic [7:0] OP_CGRAM_MASK = 8'hC0, OP_CGRAM_VAL = 8'h40;
  localparam logic [7:0] OP_DDRAM_MASK = 8'h80, OP_DDRAM_VAL = 8'h80;

  function automatic logic op_is(input logic [7:0] b, input logic [7:0] mask,
                                 input logic [7:0] val);
    return (b & mask) == val;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Synchronizes the LCD bus, detects E edges and measures the E high width.
// Nibble/RS/RW are presented from the last sample taken while E was high.
module lcd_sync_edge #(
  parameter int E_MIN_HIGH = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lcd_data,
  input  logic [2:0] lcd_ctrl,
  output logic       e_rise,
  output logic       e_fall,
  output logic [3:0] nibble,
  output logic       rs,
  output logic       rw,
  output logic       short_e
);

  localparam logic [15:0] MIN_W = 16'(E_MIN_HIGH);

  logic [6:0]  s1, s2;
  logic        e_prev;
  logic [3:0]  nib_q;
  logic        rs_q, rw_q;
  logic [15:0] high_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      e_prev   <= 1'b0;
      nib_q    <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      high_cnt <= '0;
    end else begin
      s1     <= {lcd_ctrl, lcd_data};
      s2     <= s1;
      e_prev <= s2[6];
      nib_q  <= s2[3:0];
      rs_q   <= s2[5];
      rw_q   <= s2[4];
      if (s2[6]) begin
        if (!e_prev)
          high_cnt <= 16'd1;
        else if (high_cnt != 16'hFFFF)
          high_cnt <= high_cnt + 16'd1;
      end
    end
  end

  assign e_rise  = s2[6] & ~e_prev;
  assign e_fall  = ~s2[6] & e_prev;
  assign nibble  = nib_q;
  assign rs      = rs_q;
  assign rw      = rw_q;
  assign short_e = high_cnt < MIN_W;

endmodule

// File: rtl/hd44780_responder.sv
// Bus-level model of an HD44780 character LCD: decodes 8/4-bit strobes,
// maintains a 32-entry DDRAM and flags controller timing/protocol errors.
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int E_MIN_HIGH = 10,
  parameter int CMD_GAP    = 2000,
  parameter int CLEAR_GAP  = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lcd_data,
  input  logic [2:0] lcd_ctrl,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] cmd_byte,
  output logic [4:0] cur_addr,
  output logic       mode_4bit,
  output logic       display_on,
  output logic [3:0] err
);

  localparam int GAP_MAX = (CLEAR_GAP > CMD_GAP) ? CLEAR_GAP : CMD_GAP;

  logic       rst_sync_n;
  logic       e_rise, e_fall, short_e, s_rs, s_rw;
  logic [3:0] nibble;

  state_t      state;
  logic        inc;
  logic [3:0]  hi_nib;
  logic        hi_rs;
  logic [4:0]  clr_idx;
  logic [31:0] gap_cnt;
  logic        after_clear;
  logic [7:0]  ddram [32];

  logic       strobe_ok, gap_ok;
  logic [7:0] byte_full;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  // Reset asserts immediately; release lets the core run from the second clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_n <= 1'b0;
    else        rst_sync_n <= 1'b1;
  end

  lcd_sync_edge #(.E_MIN_HIGH(E_MIN_HIGH)) u_sync (
    .clk      (clk),
    .rst_n    (rst_sync_n),
    .lcd_data (lcd_data),
    .lcd_ctrl (lcd_ctrl),
    .e_rise   (e_rise),
    .e_fall   (e_fall),
    .nibble   (nibble),
    .rs       (s_rs),
    .rw       (s_rw),
    .short_e  (short_e)
  );

  assign strobe_ok = e_fall & ~short_e & ~s_rw;
  assign byte_full = {hi_nib, nibble};
  assign gap_ok    = after_clear ? (gap_cnt >= 32'(CLEAR_GAP))
                                 : (gap_cnt >= 32'(CMD_GAP));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cur_addr;
    wr_data = byte_full;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = BLANK_CHAR;
    end else if (state == LO && strobe_ok && s_rs == hi_rs && hi_rs) begin
      wr_en = 1'b1;
    end
  end

  // DDRAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) ddram[wr_addr] <= wr_data;
  end

  assign rd_data = ddram[rd_addr];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= INIT8;
      mode_4bit   <= 1'b0;
      display_on  <= 1'b0;
      inc         <= 1'b1;
      cur_addr    <= '0;
      cmd_byte    <= '0;
      cmd_valid   <= 1'b0;
      data_valid  <= 1'b0;
      err         <= '0;
      hi_nib      <= '0;
      hi_rs       <= 1'b0;
      clr_idx     <= '0;
      gap_cnt     <= 32'(GAP_MAX);
      after_clear <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (gap_cnt < 32'(GAP_MAX)) gap_cnt <= gap_cnt + 32'd1;
      if (e_rise && !gap_ok)  err[ERR_BUSY]    <= 1'b1;
      if (e_fall && short_e)  err[ERR_SHORT_E] <= 1'b1;
      if (e_fall && s_rw)     err[ERR_RW]      <= 1'b1;

      case (state)
        INIT8: begin
          if (strobe_ok && (nibble == 4'h3 || nibble == 4'h2)) begin
            cmd_byte    <= {nibble, 4'h0};
            cmd_valid   <= 1'b1;
            gap_cnt     <= '0;
            after_clear <= 1'b0;
            if (nibble == 4'h2) begin
              mode_4bit <= 1'b1;
              state     <= HI;
            end
          end
        end
        HI: begin
          if (strobe_ok) begin
            hi_nib <= nibble;
            hi_rs  <= s_rs;
            state  <= LO;
          end
        end
        LO: begin
          if (strobe_ok) begin
            state <= HI;
            if (s_rs != hi_rs) begin
              err[ERR_RS] <= 1'b1;
            end else begin
              cmd_byte    <= byte_full;
              gap_cnt     <= '0;
              after_clear <= 1'b0;
              if (hi_rs) begin
                data_valid <= 1'b1;
                cur_addr   <= inc ? cur_addr + 5'd1 : cur_addr - 5'd1;
              end else begin
                cmd_valid <= 1'b1;
                if (op_is(byte_full, OP_CLEAR_MASK, OP_CLEAR_VAL)) begin
                  state       <= CLEAR;
                  clr_idx     <= '0;
                  after_clear <= 1'b1;
                end else if (op_is(byte_full, OP_HOME_MASK, OP_HOME_VAL)) begin
                  cur_addr <= '0;
                end else if (op_is(byte_full, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
                  inc <= byte_full[1];
                end else if (op_is(byte_full, OP_DISP_MASK, OP_DISP_VAL)) begin
                  display_on <= byte_full[2];
                end else if (op_is(byte_full, OP_FUNC_MASK, OP_FUNC_VAL)) begin
                  if (byte_full[4]) begin
                    mode_4bit <= 1'b0;
                    state     <= INIT8;
                  end
                end else if (op_is(byte_full, OP_DDRAM_MASK, OP_DDRAM_VAL)) begin
                  cur_addr <= {byte_full[6], byte_full[3:0]};
                end
              end
            end
          end
        end
        CLEAR: begin
          // The fill owns the DDRAM port; any strobe now is a busy violation.
          if (e_fall) err[ERR_BUSY] <= 1'b1;
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            cur_addr <= '0;
            inc      <= 1'b1;
            state    <= HI;
          end
        end
        default: state <= INIT8;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_responder.sv
// Scoreboard bench for hd44780_responder: directed controller traffic with
// expected cmd/data pulses queued at issue time and checked by a monitor.
module tb_hd44780_responder;

  localparam int EMIN = 10;
  localparam int GAP  = 100;
  localparam int CGAP = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lcd_data;
  logic [2:0] lcd_ctrl;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid, data_valid;
  logic [7:0] cmd_byte;
  logic [4:0] cur_addr;
  logic       mode_4bit, display_on;
  logic [3:0] err;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  hd44780_responder #(.E_MIN_HIGH(EMIN), .CMD_GAP(GAP), .CLEAR_GAP(CGAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_data   (lcd_data),
    .lcd_ctrl   (lcd_ctrl),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_valid  (cmd_valid),
    .data_valid (data_valid),
    .cmd_byte   (cmd_byte),
    .cur_addr   (cur_addr),
    .mode_4bit  (mode_4bit),
    .display_on (display_on),
    .err        (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkDdram(input int a, input logic [7:0] expected);
    @(negedge clk);
    rd_addr = 5'(a);
    #1;
    checkOutput($sformatf("ddram[%0d]", a), {24'd0, rd_data}, {24'd0, expected});
  endtask

  // E is raised one cycle after data/RS/RW settle and held for 'high' cycles.
  task automatic strobe(input logic [3:0] nib, input logic rs, input logic rw,
                        input int high, input int tail);
    @(negedge clk);
    lcd_data = nib;
    lcd_ctrl = {1'b0, rs, rw};
    @(negedge clk);
    lcd_ctrl[2] = 1'b1;
    repeat (high) @(negedge clk);
    lcd_ctrl[2] = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  task automatic applyInit8(input logic [3:0] nib);
    sb.push_back({1'b0, nib, 4'h0});
    strobe(nib, 1'b0, 1'b0, 12, 4);
    repeat (GAP + 20) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic rs, input int post);
    sb.push_back({rs, b});
    strobe(b[7:4], rs, 1'b0, 12, 4);
    strobe(b[3:0], rs, 1'b0, 12, 4);
    repeat (post) @(negedge clk);
  endtask

  // Monitor: every cmd/data pulse must match the oldest expected event.
  initial begin
    logic [8:0] exp_evt;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (cmd_valid === 1'b1 || data_valid === 1'b1)) begin
        checks++;
        if (cmd_valid && data_valid) begin
          errors++;
          $display("[TB] FAIL pulse_overlap actual=both expected=one");
        end else if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pulse actual=%b/0x%0h expected=none",
                   data_valid, cmd_byte);
        end else begin
          exp_evt = sb.pop_front();
          if ({data_valid, cmd_byte} !== exp_evt) begin
            errors++;
            $display("[TB] FAIL pulse actual=%b/0x%0h expected=%b/0x%0h",
                     data_valid, cmd_byte, exp_evt[8], exp_evt[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] hello [5];
    logic       seen;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    rst_n    = 1'b0;
    lcd_data = '0;
    lcd_ctrl = '0;
    rd_addr  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_byte", {24'd0, cmd_byte}, 32'h0);
    checkOutput("rst_cur_addr", {27'd0, cur_addr}, 32'h0);
    checkOutput("rst_mode_4bit", {31'd0, mode_4bit}, 32'h0);
    checkOutput("rst_display_on", {31'd0, display_on}, 32'h0);
    checkOutput("rst_err", {28'd0, err}, 32'h0);
    checkOutput("rst_valids", {30'd0, cmd_valid, data_valid}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] power-on sequence");
    applyInit8(4'h3);
    applyInit8(4'h3);
    applyInit8(4'h3);
    applyInit8(4'h2);
    checkOutput("init8_mode_4bit", {31'd0, mode_4bit}, 32'h1);
    applyStimulus(8'h28, 1'b0, GAP + 20);
    applyStimulus(8'h0C, 1'b0, GAP + 20);
    applyStimulus(8'h06, 1'b0, GAP + 20);
    applyStimulus(8'h01, 1'b0, CGAP + 50);
    checkOutput("init_mode_4bit", {31'd0, mode_4bit}, 32'h1);
    checkOutput("init_display_on", {31'd0, display_on}, 32'h1);
    checkOutput("init_err", {28'd0, err}, 32'h0);
    checkOutput("init_cur_addr", {27'd0, cur_addr}, 32'h0);
    for (int a = 0; a < 32; a++) checkDdram(a, 8'h20);

    $display("[TB] HELLO write");
    applyStimulus(8'h80, 1'b0, GAP + 20);
    for (int i = 0; i < 5; i++) applyStimulus(hello[i], 1'b1, GAP + 20);
    for (int i = 0; i < 5; i++) checkDdram(i, hello[i]);
    checkOutput("hello_cur_addr", {27'd0, cur_addr}, 32'd5);

    $display("[TB] address wrap");
    applyStimulus(8'hCF, 1'b0, GAP + 20);
    checkOutput("setaddr_cur_addr", {27'd0, cur_addr}, 32'd31);
    applyStimulus(8'h41, 1'b1, GAP + 20);
    applyStimulus(8'h42, 1'b1, GAP + 20);
    checkDdram(31, 8'h41);
    checkDdram(0, 8'h42);
    checkOutput("wrap_cur_addr", {27'd0, cur_addr}, 32'd1);

    $display("[TB] RS mismatch");
    strobe(4'h5, 1'b1, 1'b0, 12, 4);
    strobe(4'hA, 1'b0, 1'b0, 12, 4);
    repeat (GAP + 20) @(negedge clk);
    checkOutput("rs_err", {28'd0, err}, 32'h4);
    checkDdram(1, 8'h45);
    checkOutput("rs_cur_addr", {27'd0, cur_addr}, 32'd1);
    applyStimulus(8'h5A, 1'b1, GAP + 20);
    checkDdram(1, 8'h5A);
    checkOutput("after_rs_cur_addr", {27'd0, cur_addr}, 32'd2);

    $display("[TB] timing errors");
    strobe(4'h0, 1'b0, 1'b0, 5, 4);
    repeat (GAP + 20) @(negedge clk);
    checkOutput("short_e_err", {28'd0, err}, 32'h6);
    applyStimulus(8'h0C, 1'b0, 50);
    applyStimulus(8'h0C, 1'b0, GAP + 20);
    checkOutput("busy_err", {28'd0, err}, 32'h7);
    strobe(4'h0, 1'b0, 1'b1, 12, 4);
    repeat (20) @(negedge clk);
    checkOutput("rw_err", {28'd0, err}, 32'hF);

    $display("[TB] reset during clear");
    sb.push_back({1'b0, 8'h01});
    strobe(4'h0, 1'b0, 1'b0, 12, 4);
    strobe(4'h1, 1'b0, 1'b0, 12, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("clear_cmd_seen", {31'd0, seen}, 32'h1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midclr_cmd_byte", {24'd0, cmd_byte}, 32'h0);
    checkOutput("midclr_cur_addr", {27'd0, cur_addr}, 32'h0);
    checkOutput("midclr_mode_4bit", {31'd0, mode_4bit}, 32'h0);
    checkOutput("midclr_display_on", {31'd0, display_on}, 32'h0);
    checkOutput("midclr_err", {28'd0, err}, 32'h0);
    checkOutput("midclr_valids", {30'd0, cmd_valid, data_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkDdram(0, 8'h20);
    checkDdram(31, 8'h41);
    applyInit8(4'h3);
    checkOutput("post_rst_mode_4bit", {31'd0, mode_4bit}, 32'h0);
    applyInit8(4'h2);
    checkOutput("post_rst_4bit_entry", {31'd0, mode_4bit}, 32'h1);
    checkOutput("post_rst_err", {28'd0, err}, 32'h0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd44780_responder.md
HD44780_RESPONDER -- requirements
Module: hd44780_responder

Interface
REQ-001 Parameter E_MIN_HIGH, default 10, minimum E high width in clk cycles.
REQ-002 Parameter CMD_GAP, default 2000, minimum clk cycles from completed byte to next E rise.
REQ-003 Parameter CLEAR_GAP, default 80000, minimum clk cycles from completed clear (0x01) to next E rise.
REQ-004 clk  in  1  single system clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 lcd_data  in  4  nibble bus driven by the LCD controller (DB7..DB4).
REQ-007 lcd_ctrl  in  3  controller strobes {E, RS, RW}.
REQ-008 rd_addr  in  5  DDRAM readback address.
REQ-009 rd_data  out  8  DDRAM[rd_addr], combinational.
REQ-010 cmd_valid  out  1  one-cycle pulse, decoded instruction byte on cmd_byte.
REQ-011 data_valid  out  1  one-cycle pulse, data byte written, value on cmd_byte.
REQ-012 cmd_byte  out  8  last assembled byte.
REQ-013 cur_addr  out  5  DDRAM address counter.
REQ-014 mode_4bit  out  1  interface in 4-bit mode.
REQ-015 display_on  out  1  display control D bit.
REQ-016 err  out  4  sticky {rw_read, rs_mismatch, short_e, busy_violation}.

Function
REQ-017 lcd_data and lcd_ctrl SHALL pass a 2-flop synchronizer; all timing counts synchronized samples.
REQ-018 Nibble and RS SHALL be captured on synchronized E falling edge; 2-cycle latency E-fall to capture.
REQ-019 E high shorter than E_MIN_HIGH SHALL set err[1] and discard the nibble.
REQ-020 RW=1 at E fall SHALL set err[3] and discard the nibble.
REQ-021 FSM states: INIT8, HI, LO, CLEAR.
REQ-022 INIT8: each strobe is one instruction (upper nibble, low nibble 0); 0x3 -> stay, cmd_valid pulse; 0x2 -> mode_4bit=1, go HI; others ignored.
REQ-023 HI: capture high nibble and RS, go LO; LO: assemble byte, decode, go HI (or CLEAR).
REQ-024 RS differing between HI and LO nibble SHALL set err[2], drop byte, return HI.
REQ-025 RS=1 byte: DDRAM[cur_addr]<=byte, data_valid pulse, cur_addr +1 if I/D=1 else -1, wrapping 31<->0.
REQ-026 RS=0 decode: 0x01 clear -> CLEAR; 0x02-0x03 cur_addr=0; 0x04-0x07 latch I/D=bit1; 0x08-0x0F display_on=bit2; 0x10-0x1F, 0x40-0x7F accepted, no effect; 0x20-0x3F bit4=1 -> mode_4bit=0, INIT8; 0x80+ cur_addr={byte[6],byte[3:0]}.
REQ-027 Every decoded RS=0 byte SHALL pulse cmd_valid exactly once, same cycle as the state update.
REQ-028 CLEAR: write 0x20 to DDRAM[0..31], one entry per cycle (32 cycles), then cur_addr=0, I/D=1, go HI.
REQ-029 Strobes arriving during CLEAR SHALL set err[0] and be discarded.
REQ-030 Gap counter restarts at each completed byte; E rise before CMD_GAP (CLEAR_GAP after 0x01) elapsed SHALL set err[0]; byte still processed.
REQ-031 err bits are sticky until reset.

Reset
REQ-032 rst_n low SHALL force state INIT8, mode_4bit=0, display_on=0, I/D=1, cur_addr=0, cmd_byte=0, cmd_valid=0, data_valid=0, err=0, gap counter expired.
REQ-033 DDRAM content SHALL not be reset; reset mid-CLEAR abandons the fill.
REQ-034 Deassertion SHALL be synchronized; first active edge is the second clk after release.

Structure
REQ-035 Shared package hd44780_pkg: state enum, instruction opcode masks, ERR_* bit indices, blank char 0x20.
REQ-036 One sub-module lcd_sync_edge: 2-flop synchronizer plus E rise/fall detect and high-width counter.

Verification
REQ-037 Controller power-on sequence 0x3,0x3,0x3,0x2 then 0x28,0x0C,0x06,0x01 with legal gaps -> mode_4bit=1, display_on=1, rd_data 0x20 at all addresses, err=0.
REQ-038 After init, 0x80 then data "HELLO" -> DDRAM[0..4]=48 45 4C 4C 4F, cur_addr=5, five data_valid pulses.
REQ-039 0xCF then data 0x41,0x42 -> DDRAM[31]=0x41, DDRAM[0]=0x42 (wrap), cur_addr=1.
REQ-040 High nibble RS=1, low nibble RS=0 -> err=4'b0100, no DDRAM write, next legal byte accepted.
REQ-041 E high 5 cycles -> err[1]; E rise 1000 cycles after byte -> err[0]; RW=1 strobe -> err[3].
REQ-042 rst_n low during CLEAR (cycle 10) -> all outputs per REQ-032, state INIT8.
